// File: rtl/wb_spi_pkg.sv
// wb_spi_pkg: shared constants for the Wishbone SPI register front-end.
//   - register byte offsets inside the 64-byte window
//   - STATUS and IRQ_EN bit positions
//   - response sequencer state type
package wb_spi_pkg;

    localparam logic [5:0] OFF_DATA   = 6'h10;
    localparam logic [5:0] OFF_CMD    = 6'h20;
    localparam logic [5:0] OFF_STATUS = 6'h30;
    localparam logic [5:0] OFF_IRQEN  = 6'h34;

    localparam int unsigned STAT_TX_EMPTY = 0;
    localparam int unsigned STAT_TX_FULL  = 1;
    localparam int unsigned STAT_RX_EMPTY = 2;
    localparam int unsigned STAT_RX_FULL  = 3;
    localparam int unsigned STAT_RX_OVF   = 4;
    localparam int unsigned STAT_TX_CNT_LO = 8;
    localparam int unsigned STAT_RX_CNT_LO = 16;

    localparam int unsigned IRQ_RX_NE    = 0;
    localparam int unsigned IRQ_TX_EMPTY = 1;
    localparam int unsigned IRQ_RX_OVF   = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } resp_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO with combinational head output.
//   clk, rst (async active-low)
//   push/din   : write side; accepted when not full, or when full with a pop
//   pop        : read side; ignored when empty
//   dout       : current head word
//   full/empty : occupancy flags
//   count      : number of stored words, 0..DEPTH
module spi_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // A pop frees the head slot in the same cycle, so a push is still
    // taken when full; the write lands in the slot being read out.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_spi_regif.sv
// wb_spi_regif: Wishbone classic slave register front-end for the SPI core.
//   Bus    : wb_addr/wb_we/wb_stb/wb_cyc/wb_dout in; wb_din/wb_ack/wb_err out
//            (registered, one response cycle per accepted transfer)
//   Config : cfg word and cfg_wr pulse in the ack cycle of a CMD write
//   TX     : tx_data/tx_valid stream out, popped by tx_ready
//   RX     : rx_data/rx_valid push from the core (not stallable)
//   irq    : registered level interrupt from IRQ_EN-masked sources
module wb_spi_regif
    import wb_spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TX_W      = 12,
    parameter int          RX_W      = 10,
    parameter int          CFG_W     = 12,
    parameter int          DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_addr,
    input  logic              wb_we,
    input  logic              wb_stb,
    input  logic              wb_cyc,
    input  logic [31:0]       wb_dout,
    output logic [31:0]       wb_din,
    output logic              wb_ack,
    output logic              wb_err,
    output logic [CFG_W-1:0]  cfg,
    output logic              cfg_wr,
    output logic [TX_W-1:0]   tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [RX_W-1:0]   rx_data,
    input  logic              rx_valid,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    resp_state_t   state;
    logic [2:0]    irq_en;
    logic          rx_ovf;

    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [RX_W-1:0] rx_head;

    logic [31:0]   off;
    logic          hit, is_data, is_cmd, is_status, is_irqen;
    logic          accept, bad;
    logic          tx_push, rx_pop, rx_push;
    logic          ovf_set, ovf_clr;
    logic          cfg_we, irqen_we;
    logic [31:0]   status;
    logic [31:0]   rd_data;
    logic          unused_sig;

    assign unused_sig = ^{wb_dout, off};

    assign accept = (state == S_IDLE) & wb_stb & wb_cyc & ~wb_ack & ~wb_err;

    always_comb begin
        off       = wb_addr - BASE_ADDR;
        hit       = (off[31:6] == '0) && (off[1:0] == 2'b00);
        is_data   = hit && (off[5:0] == OFF_DATA);
        is_cmd    = hit && (off[5:0] == OFF_CMD);
        is_status = hit && (off[5:0] == OFF_STATUS);
        is_irqen  = hit && (off[5:0] == OFF_IRQEN);

        // TX full is judged before any same-cycle core pop.
        tx_push   = accept & is_data & wb_we & ~tx_full;
        rx_pop    = accept & is_data & ~wb_we & ~rx_empty;
        bad       = ~(is_data | is_cmd | is_status | is_irqen) |
                    (is_data & wb_we & tx_full);
        cfg_we    = accept & is_cmd & wb_we;
        irqen_we  = accept & is_irqen & wb_we;
        ovf_clr   = accept & is_status & wb_we & wb_dout[STAT_RX_OVF];

        // A same-cycle bus pop makes room for the core's word.
        rx_push   = rx_valid & (~rx_full | rx_pop);
        ovf_set   = rx_valid & rx_full & ~rx_pop;

        status = '0;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_RX_OVF]   = rx_ovf;
        status[STAT_TX_CNT_LO +: 8] = 8'(tx_count);
        status[STAT_RX_CNT_LO +: 8] = 8'(rx_count);

        rd_data = '0;
        if (!wb_we) begin
            if (is_data && !rx_empty) rd_data = 32'(rx_head);
            if (is_cmd)               rd_data = 32'(cfg);
            if (is_status)            rd_data = status;
            if (is_irqen)             rd_data = 32'(irq_en);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            wb_din <= '0;
            cfg    <= '0;
            cfg_wr <= 1'b0;
            irq_en <= '0;
            rx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            wb_din <= '0;
            cfg_wr <= 1'b0;
            // Set wins over a same-cycle clear.
            rx_ovf <= ovf_set | (rx_ovf & ~ovf_clr);
            irq    <= (irq_en[IRQ_RX_NE]    & ~rx_empty) |
                      (irq_en[IRQ_TX_EMPTY] &  tx_empty) |
                      (irq_en[IRQ_RX_OVF]   &  rx_ovf);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_RESP;
                        wb_ack <= ~bad;
                        wb_err <= bad;
                        wb_din <= rd_data;
                        if (cfg_we) begin
                            cfg    <= wb_dout[CFG_W-1:0];
                            cfg_wr <= 1'b1;
                        end
                        if (irqen_we) irq_en <= wb_dout[2:0];
                    end
                end
                S_RESP: state <= S_IDLE;
            endcase
        end
    end

    spi_sync_fifo #(.W(TX_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_ready),
        .din   (wb_dout[TX_W-1:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid = ~tx_empty;

    spi_sync_fifo #(.W(RX_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule

// File: tb/tb_wb_spi_regif.sv
// tb_wb_spi_regif: directed bench for wb_spi_regif with a queue-based
// reference model checked every cycle, plus literal expectations.
module tb_wb_spi_regif;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int TX_W  = 12;
    localparam int RX_W  = 10;
    localparam int CFG_W = 12;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       wb_addr = '0;
    logic              wb_we = 1'b0;
    logic              wb_stb = 1'b0;
    logic              wb_cyc = 1'b0;
    logic [31:0]       wb_dout = '0;
    logic [31:0]       wb_din;
    logic              wb_ack;
    logic              wb_err;
    logic [CFG_W-1:0]  cfg;
    logic              cfg_wr;
    logic [TX_W-1:0]   tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [RX_W-1:0]   rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_spi_regif #(
        .BASE_ADDR (BASE),
        .TX_W      (TX_W),
        .RX_W      (RX_W),
        .CFG_W     (CFG_W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_addr  (wb_addr),
        .wb_we    (wb_we),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_dout  (wb_dout),
        .wb_din   (wb_din),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .cfg      (cfg),
        .cfg_wr   (cfg_wr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TX_W-1:0]  tx_q[$];
    logic [RX_W-1:0]  rx_q[$];
    logic [CFG_W-1:0] m_cfg = '0;
    logic [2:0]       m_en = '0;
    bit               m_ovf = 0;
    bit               e_ack = 0, e_err = 0, e_cfg_wr = 0, e_irq = 0;
    logic [31:0]      e_din = '0;

    int unsigned m_txn, m_rxn;
    bit          m_acc, m_set, m_clr, n_ack, n_err, n_cw, n_irq;
    logic [31:0] m_off, n_din;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q.delete(); rx_q.delete();
            m_cfg = '0; m_en = '0; m_ovf = 0;
            e_ack = 0; e_err = 0; e_cfg_wr = 0; e_irq = 0; e_din = '0;
        end else begin
            m_txn = tx_q.size();
            m_rxn = rx_q.size();
            n_irq = (m_en[0] && m_rxn != 0) || (m_en[1] && m_txn == 0) || (m_en[2] && m_ovf);
            m_acc = wb_stb && wb_cyc && !e_ack && !e_err;
            n_ack = 0; n_err = 0; n_cw = 0; n_din = '0; m_set = 0; m_clr = 0;
            if (tx_ready && m_txn != 0) void'(tx_q.pop_front());
            if (m_acc) begin
                m_off = wb_addr - BASE;
                if (m_off >= 64 || m_off % 4 != 0) n_err = 1;
                else if (m_off == 'h10) begin
                    if (wb_we) begin
                        if (m_txn == DEPTH) n_err = 1;
                        else begin tx_q.push_back(wb_dout[TX_W-1:0]); n_ack = 1; end
                    end else begin
                        n_ack = 1;
                        if (m_rxn != 0) n_din = 32'(rx_q.pop_front());
                    end
                end else if (m_off == 'h20) begin
                    n_ack = 1;
                    if (wb_we) begin m_cfg = wb_dout[CFG_W-1:0]; n_cw = 1; end
                    else n_din = 32'(m_cfg);
                end else if (m_off == 'h30) begin
                    n_ack = 1;
                    if (wb_we) m_clr = wb_dout[4];
                    else n_din = m_rxn * 32'h1_0000 + m_txn * 32'h100 +
                                 (m_ovf ? 16 : 0) + (m_rxn == DEPTH ? 8 : 0) +
                                 (m_rxn == 0 ? 4 : 0) + (m_txn == DEPTH ? 2 : 0) +
                                 (m_txn == 0 ? 1 : 0);
                end else if (m_off == 'h34) begin
                    n_ack = 1;
                    if (wb_we) m_en = wb_dout[2:0];
                    else n_din = 32'(m_en);
                end else n_err = 1;
            end
            if (rx_valid) begin
                if (rx_q.size() < DEPTH) rx_q.push_back(rx_data);
                else m_set = 1;
            end
            m_ovf = m_set || (m_ovf && !m_clr);
            e_ack = n_ack; e_err = n_err; e_din = n_din; e_cfg_wr = n_cw; e_irq = n_irq;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("ack", 32'(wb_ack), 32'(e_ack));
        chk("err", 32'(wb_err), 32'(e_err));
        if (e_ack) chk("din", wb_din, e_din);
        chk("cfg", 32'(cfg), 32'(m_cfg));
        chk("cfg_wr", 32'(cfg_wr), 32'(e_cfg_wr));
        chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
        chk("irq", 32'(irq), 32'(e_irq));
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic [31:0] a, input bit we, input logic [31:0] d,
                       output logic [31:0] rd, output bit ack, output bit err);
        @(negedge clk);
        wb_addr = a; wb_we = we; wb_dout = d; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(negedge clk);
        ack = wb_ack; err = wb_err; rd = wb_din;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        chk("resp_latency", 32'(ack | err), 32'd1);
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d, input bit exp_err);
        logic [31:0] rd; bit ack, err;
        bus(a, 1'b1, d, rd, ack, err);
        chk({name, "_ack"}, 32'(ack), 32'(!exp_err));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rdc(input string name, input logic [31:0] a, input logic [31:0] exp, input bit exp_err);
        logic [31:0] rd; bit ack, err;
        bus(a, 1'b0, '0, rd, ack, err);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_data"}, rd, exp);
    endtask

    task automatic rx_push(input logic [RX_W-1:0] d);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit a0, a1, a2, a3;

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wb_ack), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_cfg", 32'(cfg), 0);
        rst = 1'b1;

        // CMD write/read at relocated base
        wr("cmd_wr", 32'h120, 32'h0000_0ABC, 0);
        chk("cfg_val", 32'(cfg), 32'hABC);
        chk("cfg_wr_pulse", 32'(cfg_wr), 1);
        @(negedge clk);
        chk("cfg_wr_low", 32'(cfg_wr), 0);
        rdc("cmd_rd", 32'h120, 32'h0000_0ABC, 0);

        // TX fill to full, overflow write errors
        for (int i = 1; i <= 5; i++) wr("tx_wr", 32'h110, 32'(i), i == 5);
        rdc("stat_txfull", 32'h130, 32'h0000_0406, 0);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            chk("tx_drain_v", 32'(tx_valid), 1);
            chk("tx_drain_d", 32'(tx_data), 32'(i));
            tx_ready = 1'b1;
            @(negedge clk);
        end
        chk("tx_empty_v", 32'(tx_valid), 0);
        tx_ready = 1'b0;

        // RX overflow
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_data = RX_W'(10'h3F0 + i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rdc("stat_rxovf", 32'h130, 32'h0004_0019, 0);
        for (int i = 0; i < 4; i++) rdc("rx_rd", 32'h110, 32'h3F0 + 32'(i), 0);
        rdc("rx_rd_empty", 32'h110, 32'h0, 0);
        rdc("stat_ovf_only", 32'h130, 32'h0000_0015, 0);
        wr("w1c", 32'h130, 32'h0000_0010, 0);
        rdc("stat_clr", 32'h130, 32'h0000_0005, 0);

        // IRQ on RX not empty
        wr("irqen_wr", 32'h134, 32'h1, 0);
        rdc("irqen_rd", 32'h134, 32'h1, 0);
        rx_push(10'h155);
        chk("irq_pre", 32'(irq), 0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 1);
        rdc("irq_pop", 32'h110, 32'h155, 0);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 0);

        // Error responses, no side effects
        rdc("bad_off_rd", 32'h108, 32'h0, 1);
        wr("bad_off_wr", 32'h108, 32'hFFFF_FFFF, 1);
        wr("oow_wr", 32'h200, 32'h0000_0123, 1);
        rdc("below_base", 32'h0000_0020, 32'h0, 1);
        rdc("misaligned", 32'h122, 32'h0, 1);
        rdc("cmd_keep", 32'h120, 32'h0000_0ABC, 0);
        rdc("irqen_keep", 32'h134, 32'h1, 0);

        // Held strobe: acks two cycles apart
        @(negedge clk);
        wb_addr = 32'h120; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(negedge clk); a0 = wb_ack;
        @(negedge clk); a1 = wb_ack;
        @(negedge clk); a2 = wb_ack;
        @(negedge clk); a3 = wb_ack;
        wb_stb = 1'b0; wb_cyc = 1'b0;
        chk("b2b_pattern", 32'({a0, a1, a2, a3}), 32'b1010);

        // Reset during a pending transfer
        wr("pre_cfg", 32'h120, 32'h0000_05A5, 0);
        wr("pre_tx", 32'h110, 32'h7, 0);
        rx_push(10'h0AA);
        @(negedge clk);
        chk("pre_irq", 32'(irq), 1);
        wb_addr = 32'h120; wb_we = 1'b1; wb_dout = 32'h123; wb_stb = 1'b1; wb_cyc = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_ack", 32'(wb_ack), 0);
        chk("mid_err", 32'(wb_err), 0);
        chk("mid_din", wb_din, 0);
        chk("mid_cfg", 32'(cfg), 0);
        chk("mid_txv", 32'(tx_valid), 0);
        chk("mid_irq", 32'(irq), 0);
        repeat (2) @(negedge clk);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        rst = 1'b1;
        rdc("post_stat", 32'h130, 32'h0000_0005, 0);
        rdc("post_irqen", 32'h134, 32'h0, 0);
        rdc("post_rx", 32'h110, 32'h0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
